pe_array_ctrl: RTL
==================

// Module: pe_array_ctrl
//
// PURPOSE
//  Sequencer for a ROWS x COLS systolic array of weight-stationary PEs.
//  Per job it runs two phases:
//   - loads one weight row per beat by driving the shared PE ctrl line high, so weights ripple down the psum path;
//   - streams num_vec feature vectors with ctrl low, then drains the array.
//  Sits between the weight/feature input buffers and the PE array; tells the output collector when psums are valid.
//
// PARAMETERS
//  ROWS       4  PE rows; number of weight beats per load
//  COLS       4  PE columns; adds to pipeline latency
//  NUM_VEC_W  8  width of the feature-vector count
//
// PORTS
//  clk_in          in   1               clock, rising edge
//  nrst_in         in   1               async active-low reset
//  start_in        in   1               job start; sampled only in IDLE
//  num_vec_in      in   NUM_VEC_W       feature vectors in the job; latched at start
//  busy_out        out  1               high whenever state != IDLE
//  done_out        out  1               1-cycle pulse at job end
//  w_valid_in      in   1               weight buffer has a row
//  w_ready_out     out  1               controller accepts a weight row
//  f_valid_in      in   1               feature buffer has a vector
//  f_ready_out     out  1               controller accepts a feature vector
//  pe_ctrl_out     out  1               to all PE ctrl_in (1 = weight pass-through)
//  feat_en_out     out  1               inject feature / advance skew regs this cycle
//  psum_valid_out  out  1               psum column outputs valid this cycle
//  row_idx_out     out  $clog2(ROWS)    weight row being loaded
//  vec_cnt_out     out  NUM_VEC_W       features accepted in this job
//
// BEHAVIOUR
//  - Reset (async, nrst_in low): all outputs 0, state IDLE, counters and valid pipe cleared, latched count 0.
//    Reset mid-job aborts immediately; no done_out pulse.
//  - LAT = ROWS+COLS-1.
//  - Handshakes: a beat transfers when valid && ready in the same cycle. Ready never depends on valid.
//  - States and transitions:
//    - IDLE:
//      - start_in && num_vec_in != 0: latch count, clear row_idx and vec_cnt, go to LOAD_W.
//      - start_in && num_vec_in == 0: go to DONE.
//    - LOAD_W:
//      - Outputs: w_ready_out=1, pe_ctrl_out=1.
//      - row_idx increments on each w transfer; it holds while w_valid_in is low.
//      - The transfer with row_idx == ROWS-1 goes to COMPUTE.
//    - COMPUTE:
//      - Outputs: pe_ctrl_out=0, f_ready_out=1, feat_en_out = f_valid_in (combinational).
//      - vec_cnt increments on each transfer.
//      - The transfer that reaches the latched count goes to DRAIN.
//    - DRAIN:
//      - Outputs: all readies 0, feat_en_out=0.
//      - Stays exactly LAT cycles, then goes to DONE.
//    - DONE:
//      - done_out=1 for one cycle, then IDLE.
//      - busy_out stays high during DONE.
//  - Valid pipe: LAT-deep shift register fed by feat_en_out. psum_valid_out is the last tap.
//    - psum_valid_out is high exactly LAT cycles after each accepted feature, preserving bubbles.
//    - The last psum_valid falls on the final DRAIN cycle.
//  - pe_ctrl_out is 0 in every state except LOAD_W.
//  - start_in is ignored outside IDLE; num_vec_in is ignored after latching.
//  - vec_cnt_out holds its final value until the next accepted start.
//  - Counters never wrap inside a job; the maximum count is 2^NUM_VEC_W-1.
//
// TESTING (ROWS=COLS=4, LAT=7; start_in sampled in cycle 0)
//  1. num_vec=3, w/f valid always high -> LOAD_W cycles 1-4 (pe_ctrl high), COMPUTE 5-7,
//     psum_valid cycles 12-14, DRAIN 8-14, done_out cycle 15, busy low cycle 16.
//  2. As 1, but w_valid low in cycles 2-3 -> row_idx holds at 1, LOAD_W spans 1-6, every later event shifts +2.
//  3. num_vec=4 with f_valid pattern 1,0,1,1,0,1 -> psum_valid shows the same pattern delayed 7 cycles;
//     vec_cnt_out ends at 4.
//  4. start with num_vec=0 -> done_out in cycle 1, pe_ctrl/w_ready/f_ready never assert.
//  5. start pulsed again during COMPUTE -> ignored, job completes as in 1.
//     nrst low during COMPUTE -> all outputs 0 immediately, no done_out;
//     a following start with num_vec=1 -> done_out at start+1+4+1+7.
//  6. num_vec=255 (max) -> vec_cnt_out reaches 255 with no wrap, exactly 255 psum_valid pulses.

Source files
------------

// File: rtl/pe_array_ctrl.sv
// Sequencer for a weight-stationary systolic array: loads ROWS weight beats, streams
// the job's feature vectors, drains the pipeline and flags when psum outputs are valid.
module pe_array_ctrl #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int NUM_VEC_W = 8,
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk_in,
  input  logic                 nrst_in,
  input  logic                 start_in,
  input  logic [NUM_VEC_W-1:0] num_vec_in,
  output logic                 busy_out,
  output logic                 done_out,
  input  logic                 w_valid_in,
  output logic                 w_ready_out,
  input  logic                 f_valid_in,
  output logic                 f_ready_out,
  output logic                 pe_ctrl_out,
  output logic                 feat_en_out,
  output logic                 psum_valid_out,
  output logic [ROW_W-1:0]     row_idx_out,
  output logic [NUM_VEC_W-1:0] vec_cnt_out
);

  localparam int LAT   = ROWS + COLS - 1;
  localparam int DRN_W = $clog2(LAT + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_wReady;
  logic                 r_fReady;
  logic                 r_peCtrl;
  logic [ROW_W-1:0]     r_rowIdx;
  logic [NUM_VEC_W-1:0] r_vecCnt;
  logic [NUM_VEC_W-1:0] r_numVec;
  logic [DRN_W-1:0]     r_drainCnt;
  logic [LAT-1:0]       r_validPipe;

  logic                 w_wXfer;
  logic                 w_fXfer;
  logic [NUM_VEC_W-1:0] w_vecNext;
  logic [LAT:0]         w_pipeNext;

  assign w_wXfer    = r_wReady & w_valid_in;
  assign w_fXfer    = r_fReady & f_valid_in;
  assign w_vecNext  = r_vecCnt + 1'b1;
  assign w_pipeNext = {r_validPipe, w_fXfer};

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start_in) w_nextState = (num_vec_in != '0) ? LOAD_W : DONE;
      LOAD_W:  if (w_wXfer && (r_rowIdx == ROW_W'(ROWS - 1))) w_nextState = COMPUTE;
      COMPUTE: if (w_fXfer && (w_vecNext == r_numVec)) w_nextState = DRAIN;
      DRAIN:   if (r_drainCnt == DRN_W'(LAT - 1)) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake and status flags are registered from the next state so they change
  // cleanly on the same edge as the state itself.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wReady   <= 1'b0;
      r_fReady   <= 1'b0;
      r_peCtrl   <= 1'b0;
      r_rowIdx   <= '0;
      r_vecCnt   <= '0;
      r_numVec   <= '0;
      r_drainCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_busy   <= (w_nextState != IDLE);
      r_done   <= (w_nextState == DONE);
      r_wReady <= (w_nextState == LOAD_W);
      r_peCtrl <= (w_nextState == LOAD_W);
      r_fReady <= (w_nextState == COMPUTE);
      case (r_state)
        IDLE: begin
          if (start_in && (num_vec_in != '0)) begin
            r_numVec <= num_vec_in;
            r_rowIdx <= '0;
            r_vecCnt <= '0;
          end
        end
        LOAD_W: begin
          if (w_wXfer && (r_rowIdx != ROW_W'(ROWS - 1))) r_rowIdx <= r_rowIdx + 1'b1;
        end
        COMPUTE: begin
          if (w_fXfer) r_vecCnt <= w_vecNext;
          r_drainCnt <= '0;
        end
        DRAIN: begin
          r_drainCnt <= r_drainCnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // One tap per pipeline stage so bubbles in the feature stream reappear at the output.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_validPipe <= '0;
    end else begin
      r_validPipe <= w_pipeNext[LAT-1:0];
    end
  end

  assign busy_out       = r_busy;
  assign done_out       = r_done;
  assign w_ready_out    = r_wReady;
  assign f_ready_out    = r_fReady;
  assign pe_ctrl_out    = r_peCtrl;
  assign feat_en_out    = w_fXfer;
  assign psum_valid_out = r_validPipe[LAT-1];
  assign row_idx_out    = r_rowIdx;
  assign vec_cnt_out    = r_vecCnt;

endmodule
